// File: rtl/memmu_sr_stream_writer.sv
// Streaming SIU-to-MemMU stage: maps angleH/angleV to an entry address (optional double-buffer bank bit),
// packs a 64-bit payload, detects frame wrap on angleH and keeps per-frame and dropped-point counts.
module memmu_sr_stream_writer #(
    parameter int FOV_H         = 360,
    parameter int FOV_V         = 90,
    parameter int ADDR_BITS_H   = 11,
    parameter int ADDR_BITS_V   = 5,
    parameter int NUM_RETURNS   = 2,
    parameter int DOUBLE_BUFFER = 1,
    localparam int AW = ADDR_BITS_H + ADDR_BITS_V + DOUBLE_BUFFER
) (
    input  logic          i_SYSTEM_clk,
    input  logic          i_SYSTEM_rst,
    input  logic          i_SIU_valid,
    output logic          o_SIU_ready,
    input  logic [15:0]   i_SIU_angleH,
    input  logic [15:0]   i_SIU_angleV,
    input  logic [15:0]   i_SIU_distR0,
    input  logic [15:0]   i_SIU_distR1,
    input  logic [7:0]    i_SIU_reflR0,
    input  logic [7:0]    i_SIU_reflR1,
    input  logic [7:0]    i_SIU_label,
    output logic          o_MemMU_SR_valid,
    input  logic          i_MemMU_SR_ready,
    output logic [AW-1:0] o_MemMU_SR_address,
    output logic [63:0]   o_MemMU_SR_payload,
    output logic [31:0]   o_MemMU_SR_size,
    output logic          o_frame_done,
    output logic [AW:0]   o_frame_points,
    output logic [7:0]    o_frame_id,
    output logic [15:0]   o_drop_count
);

    localparam logic [31:0] SPAN_H = 32'(FOV_H * 100);
    localparam logic [31:0] SPAN_V = 32'(FOV_V * 100);
    localparam logic [31:0] HALF_H = 32'(FOV_H * 50);
    localparam logic [AW:0] PTS_MAX = '1;

    function automatic logic [31:0] f_scaled(input logic [15:0] a, input int n);
        return {16'd0, a} << n;
    endfunction

    // Sub-index correction: fraction of one index step, truncated to 1/16ths.
    function automatic logic [3:0] f_corr(input logic [15:0] rem, input logic [31:0] span);
        return 4'(({16'd0, rem} << 4) / span);
    endfunction

    logic                   w_adv_p1, w_adv_p2;
    logic                   w_accept, w_inrange, w_take, w_drop, w_wrap;
    logic [ADDR_BITS_H-1:0] w_idxH;
    logic [ADDR_BITS_V-1:0] w_idxV;
    logic [15:0]            w_remH, w_remV;
    logic [AW-1:0]          w_addr_p1;
    logic [63:0]            w_payload_p1;

    logic                   r_vld_p1, r_bank_p1;
    logic [ADDR_BITS_H-1:0] r_idxH_p1;
    logic [ADDR_BITS_V-1:0] r_idxV_p1;
    logic [15:0]            r_remH_p1, r_remV_p1, r_dist0_p1, r_dist1_p1;
    logic [7:0]             r_refl0_p1, r_refl1_p1, r_label_p1;
    logic                   r_vld_p2;
    logic [AW-1:0]          r_addr_p2;
    logic [63:0]            r_payload_p2;

    logic                   r_bank, r_prevH_vld, r_frame_done;
    logic [15:0]            r_prevH, r_drop;
    logic [AW:0]            r_pts, r_frame_points;
    logic [7:0]             r_frame_id;

    // Each stage advances when empty or when the stage after it advances.
    assign w_adv_p2    = ~r_vld_p2 | i_MemMU_SR_ready;
    assign w_adv_p1    = ~r_vld_p1 | w_adv_p2;
    assign o_SIU_ready = w_adv_p1;

    assign w_accept  = i_SIU_valid & w_adv_p1;
    assign w_inrange = ({16'd0, i_SIU_angleH} < SPAN_H) && ({16'd0, i_SIU_angleV} < SPAN_V);
    assign w_take    = w_accept & w_inrange;
    assign w_drop    = w_accept & ~w_inrange;
    assign w_wrap    = w_take & r_prevH_vld & (({16'd0, i_SIU_angleH} + HALF_H) < {16'd0, r_prevH});

    assign w_idxH = ADDR_BITS_H'(f_scaled(i_SIU_angleH, ADDR_BITS_H) / SPAN_H);
    assign w_idxV = ADDR_BITS_V'(f_scaled(i_SIU_angleV, ADDR_BITS_V) / SPAN_V);
    assign w_remH = 16'(f_scaled(i_SIU_angleH, ADDR_BITS_H) % SPAN_H);
    assign w_remV = 16'(f_scaled(i_SIU_angleV, ADDR_BITS_V) % SPAN_V);

    generate
        if (DOUBLE_BUFFER != 0) begin : g_bank
            assign w_addr_p1 = {r_bank_p1, r_idxV_p1, r_idxH_p1};
        end else begin : g_nobank
            assign w_addr_p1 = {r_idxV_p1, r_idxH_p1};
        end
    endgenerate

    assign w_payload_p1 = {r_label_p1, r_refl1_p1, r_refl0_p1, r_dist1_p1, r_dist0_p1,
                           f_corr(r_remV_p1, SPAN_V), f_corr(r_remH_p1, SPAN_H)};

    always_ff @(posedge i_SYSTEM_clk) begin
        if (i_SYSTEM_rst) begin
            r_vld_p1       <= 1'b0;
            r_bank_p1      <= 1'b0;
            r_idxH_p1      <= '0;
            r_idxV_p1      <= '0;
            r_remH_p1      <= '0;
            r_remV_p1      <= '0;
            r_dist0_p1     <= '0;
            r_dist1_p1     <= '0;
            r_refl0_p1     <= '0;
            r_refl1_p1     <= '0;
            r_label_p1     <= '0;
            r_vld_p2       <= 1'b0;
            r_addr_p2      <= '0;
            r_payload_p2   <= '0;
            r_bank         <= 1'b0;
            r_prevH_vld    <= 1'b0;
            r_prevH        <= '0;
            r_frame_done   <= 1'b0;
            r_drop         <= '0;
            r_pts          <= '0;
            r_frame_points <= '0;
            r_frame_id     <= '0;
        end else begin
            // S1: index and remainder of the accepted point; the wrap point carries the new bank.
            if (w_adv_p1) begin
                r_vld_p1 <= w_take;
                if (w_take) begin
                    r_bank_p1  <= r_bank ^ w_wrap;
                    r_idxH_p1  <= w_idxH;
                    r_idxV_p1  <= w_idxV;
                    r_remH_p1  <= w_remH;
                    r_remV_p1  <= w_remV;
                    r_dist0_p1 <= i_SIU_distR0;
                    r_dist1_p1 <= (NUM_RETURNS == 2) ? i_SIU_distR1 : 16'd0;
                    r_refl0_p1 <= i_SIU_reflR0;
                    r_refl1_p1 <= (NUM_RETURNS == 2) ? i_SIU_reflR1 : 8'd0;
                    r_label_p1 <= i_SIU_label;
                end
            end
            // S2: final address and payload.
            if (w_adv_p2) begin
                r_vld_p2 <= r_vld_p1;
                if (r_vld_p1) begin
                    r_addr_p2    <= w_addr_p1;
                    r_payload_p2 <= w_payload_p1;
                end
            end

            r_frame_done <= w_wrap;
            if (w_wrap) begin
                r_bank         <= ~r_bank;
                r_frame_points <= r_pts;
                r_frame_id     <= r_frame_id + 8'd1;
            end
            if (w_take) begin
                r_prevH     <= i_SIU_angleH;
                r_prevH_vld <= 1'b1;
                if (w_wrap)
                    r_pts <= (AW+1)'(1);
                else if (r_pts != PTS_MAX)
                    r_pts <= r_pts + (AW+1)'(1);
            end
            if (w_drop && (r_drop != 16'hFFFF))
                r_drop <= r_drop + 16'd1;
        end
    end

    assign o_MemMU_SR_valid   = r_vld_p2;
    assign o_MemMU_SR_address = r_addr_p2;
    assign o_MemMU_SR_payload = r_payload_p2;
    assign o_MemMU_SR_size    = 32'd1 << (AW + 3);
    assign o_frame_done       = r_frame_done;
    assign o_frame_points     = r_frame_points;
    assign o_frame_id         = r_frame_id;
    assign o_drop_count       = r_drop;

endmodule

// File: tb/tb_memmu_sr_stream_writer.sv
// Directed bench for memmu_sr_stream_writer: mapping, correction, range drop, frame wrap,
// backpressure ordering/stability and mid-burst reset, with hand-computed expectations.
module tb_memmu_sr_stream_writer;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [15:0]   aH = '0, aV = '0, d0 = '0, d1 = '0;
    logic [7:0]    r0 = '0, r1 = '0, lb = '0;
    logic          m_ready = 1'b1;

    logic          s_ready, m_valid, f_done;
    logic [AW-1:0] m_addr;
    logic [63:0]   m_payload;
    logic [31:0]   m_size;
    logic [AW:0]   f_points;
    logic [7:0]    f_id;
    logic [15:0]   drops;

    logic          s_ready1, m_valid1, f_done1;
    logic [AW-1:0] m_addr1;
    logic [63:0]   m_payload1;
    logic [31:0]   m_size1;
    logic [AW:0]   f_points1;
    logic [7:0]    f_id1;
    logic [15:0]   drops1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    memmu_sr_stream_writer u_dut (
        .i_SYSTEM_clk(clk), .i_SYSTEM_rst(rst),
        .i_SIU_valid(s_valid), .o_SIU_ready(s_ready),
        .i_SIU_angleH(aH), .i_SIU_angleV(aV),
        .i_SIU_distR0(d0), .i_SIU_distR1(d1),
        .i_SIU_reflR0(r0), .i_SIU_reflR1(r1), .i_SIU_label(lb),
        .o_MemMU_SR_valid(m_valid), .i_MemMU_SR_ready(m_ready),
        .o_MemMU_SR_address(m_addr), .o_MemMU_SR_payload(m_payload),
        .o_MemMU_SR_size(m_size), .o_frame_done(f_done),
        .o_frame_points(f_points), .o_frame_id(f_id), .o_drop_count(drops)
    );

    memmu_sr_stream_writer #(.NUM_RETURNS(1)) u_dut1 (
        .i_SYSTEM_clk(clk), .i_SYSTEM_rst(rst),
        .i_SIU_valid(s_valid), .o_SIU_ready(s_ready1),
        .i_SIU_angleH(aH), .i_SIU_angleV(aV),
        .i_SIU_distR0(d0), .i_SIU_distR1(d1),
        .i_SIU_reflR0(r0), .i_SIU_reflR1(r1), .i_SIU_label(lb),
        .o_MemMU_SR_valid(m_valid1), .i_MemMU_SR_ready(m_ready),
        .o_MemMU_SR_address(m_addr1), .o_MemMU_SR_payload(m_payload1),
        .o_MemMU_SR_size(m_size1), .o_frame_done(f_done1),
        .o_frame_points(f_points1), .o_frame_id(f_id1), .o_drop_count(drops1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    // Presents one point and holds it across a single clock edge.
    task automatic push(input logic [15:0] h, input logic [15:0] v, input logic [15:0] dd0,
                        input logic [15:0] dd1, input logic [7:0] rr0, input logic [7:0] rr1,
                        input logic [7:0] l);
        aH = h; aV = v; d0 = dd0; d1 = dd1; r0 = rr0; r1 = rr1; lb = l;
        s_valid = 1'b1;
        #1 chk("push_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    logic [AW-1:0] exp_addr [6];
    logic          stalled;
    logic [63:0]   held_payload;
    logic [AW-1:0] held_addr;
    int            sent, got, cyc;
    logic          will_acc, will_out;

    initial begin
        exp_addr[0] = 17'd65592; exp_addr[1] = 17'd65649; exp_addr[2] = 17'd65706;
        exp_addr[3] = 17'd65763; exp_addr[4] = 17'd65820; exp_addr[5] = 17'd65877;

        // Reset state
        do_reset();
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_addr", 64'(m_addr), 64'd0);
        chk("rst_payload", m_payload, 64'd0);
        chk("rst_fdone", 64'(f_done), 64'd0);
        chk("rst_fid", 64'(f_id), 64'd0);
        chk("rst_drop", 64'(drops), 64'd0);
        chk("rst_fpoints", 64'(f_points), 64'd0);
        chk("size", 64'(m_size), 64'd1048576);

        // T1 mapping and latency
        push(16'd9000, 16'd4500, 16'h1111, 16'h2222, 8'h33, 8'h44, 8'h55);
        @(negedge clk);
        chk("t1_lat1_valid", 64'(m_valid), 64'd0);
        @(negedge clk);
        chk("t1_valid", 64'(m_valid), 64'd1);
        chk("t1_addr", 64'(m_addr), 64'd33280);
        chk("t1_payload", m_payload, 64'h5544332222111100);
        @(negedge clk);
        chk("t1_consumed", 64'(m_valid), 64'd0);

        // T2 correction nibbles and single-return payload
        push(16'd9010, 16'd4700, 16'hAAAA, 16'hBBBB, 8'hCC, 8'hDD, 8'hEE);
        @(negedge clk);
        chk("t2_no_wrap", 64'(f_done), 64'd0);
        @(negedge clk);
        chk("t2_addr", 64'(m_addr), 64'd33280);
        chk("t2_payload", m_payload, 64'hEEDDCCBBBBAAAAB9);
        chk("t2_payload_1ret", m_payload1, 64'hEE00CC0000AAAAB9);

        // T3 out-of-range drop leaves prevH alone
        push(16'd36000, 16'd0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        chk("t3_drop_fdone", 64'(f_done), 64'd0);
        @(negedge clk);
        chk("t3_drop_valid", 64'(m_valid), 64'd0);
        chk("t3_drop_count", 64'(drops), 64'd1);
        push(16'd100, 16'd0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        chk("t3_prevh_kept", 64'(f_done), 64'd0);
        @(negedge clk);
        chk("t3_valid", 64'(m_valid), 64'd1);
        chk("t3_addr", 64'(m_addr), 64'd5);
        chk("t3_payload", m_payload, 64'h0B);
        chk("t3_fid", 64'(f_id), 64'd0);

        // T4 frame wrap
        do_reset();
        push(16'd35000, 16'd0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        chk("t4_first_no_wrap", 64'(f_done), 64'd0);
        @(negedge clk);
        chk("t4_addr0", 64'(m_addr), 64'd1991);
        push(16'd50, 16'd0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        chk("t4_fdone", 64'(f_done), 64'd1);
        chk("t4_fpoints", 64'(f_points), 64'd1);
        chk("t4_fid", 64'(f_id), 64'd1);
        @(negedge clk);
        chk("t4_fdone_pulse", 64'(f_done), 64'd0);
        chk("t4_addr1", 64'(m_addr), 64'd65538);
        chk("t4_payload1", m_payload, 64'h0D);

        // T5 backpressure burst
        @(posedge clk);
        #1;
        sent = 0; got = 0; cyc = 0; stalled = 1'b0;
        held_payload = '0; held_addr = '0;
        while (got < 6 && cyc < 100) begin
            m_ready = (cyc % 2 == 0);
            if (sent < 6) begin
                aH = 16'(1000 * (sent + 1)); aV = 16'd0;
                d0 = 16'(sent + 1); d1 = 16'd0; r0 = 8'd0; r1 = 8'd0; lb = 8'(sent + 1);
                s_valid = 1'b1;
            end else begin
                s_valid = 1'b0;
            end
            @(negedge clk);
            will_acc = s_valid & s_ready;
            will_out = m_valid & m_ready;
            if (m_valid && stalled) begin
                chk("t5_hold_payload", m_payload, held_payload);
                chk("t5_hold_addr", 64'(m_addr), 64'(held_addr));
            end
            if (will_out) begin
                chk("t5_label", 64'(m_payload[63:56]), 64'(got + 1));
                chk("t5_dist0", 64'(m_payload[23:8]), 64'(got + 1));
                chk("t5_addr", 64'(m_addr), 64'(exp_addr[got]));
                got++;
            end
            stalled = m_valid & ~m_ready;
            held_payload = m_payload;
            held_addr = m_addr;
            if (will_acc) sent++;
            @(posedge clk);
            #1 cyc++;
        end
        s_valid = 1'b0;
        chk("t5_all_out", 64'(got), 64'd6);

        // T6 reset with two points in flight and a wrap candidate on the input
        m_ready = 1'b0;
        push(16'd30000, 16'd0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0);
        push(16'd31000, 16'd0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        chk("t6_inflight_valid", 64'(m_valid), 64'd1);
        chk("t6_inflight_addr", 64'(m_addr), 64'd67242);
        rst = 1'b1;
        aH = 16'd50; s_valid = 1'b1;
        @(negedge clk);
        chk("t6_valid", 64'(m_valid), 64'd0);
        chk("t6_fdone", 64'(f_done), 64'd0);
        chk("t6_fid", 64'(f_id), 64'd0);
        chk("t6_drop", 64'(drops), 64'd0);
        chk("t6_fpoints", 64'(f_points), 64'd0);
        rst = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        chk("t6_after_fdone", 64'(f_done), 64'd0);
        chk("t6_after_valid", 64'(m_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
